// File: rtl/npu_pkg.sv
// Shared NPU definitions: address width default, layer mode codes and the
// write-back state encoding.
package npu_pkg;

  localparam int ADDR_W_DEF = 13;

  localparam logic [2:0] MODE_CONV      = 3'd1;
  localparam logic [2:0] MODE_FC        = 3'd2;
  localparam logic [2:0] MODE_ADD       = 3'd3;
  localparam logic [2:0] MODE_POOL      = 3'd4;
  localparam logic [2:0] MODE_ACC       = 3'd5;
  localparam logic [2:0] MODE_DEPTHCONV = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/oagu_nest_cnt.sv
// x/y/p nested counter for the output write-back walk; x runs fastest and
// each level carries into the next when it reaches length-1.
module oagu_nest_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  input  logic [7:0] x_len,
  input  logic [7:0] y_len,
  input  logic [7:0] p_len,
  output logic       last
);

  logic [7:0] x, y, p;
  logic       x_end, y_end, p_end;

  assign x_end = (x == x_len - 8'd1);
  assign y_end = (y == y_len - 8'd1);
  assign p_end = (p == p_len - 8'd1);
  assign last  = x_end && y_end && p_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
      p <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
      p <= '0;
    end else if (step) begin
      if (!x_end) begin
        x <= x + 8'd1;
      end else begin
        x <= '0;
        if (!y_end) begin
          y <= y + 8'd1;
        end else begin
          y <= '0;
          p <= p_end ? 8'd0 : p + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oagu_writeback.sv
// Output address generator: streams NPE result beats into the IO buffer.
// Optional build macro OAGU_RELU_EN clamps negative results to zero.
module oagu_writeback
  import npu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] addr_start_d,
  input  logic [7:0]        out_x_length,
  input  logic [7:0]        out_y_length,
  input  logic [7:0]        out_piece,
  input  logic              i_res_valid,
  input  logic [DATA_W-1:0] i_res_data,
  output logic              o_res_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_write_end
);

  wb_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        x_len, y_len, p_len;
  logic              start_ok, accept, last;

  assign start_ok    = (state == ST_IDLE) && start_write;
  assign accept      = (state == ST_WRITE) && i_res_valid;
  assign o_res_ready = (state == ST_WRITE);
  assign o_busy      = (state != ST_IDLE);
  assign o_write_end = (state == ST_DONE);

  function automatic logic [DATA_W-1:0] wr_value(input logic [DATA_W-1:0] d);
`ifdef OAGU_RELU_EN
    return d[DATA_W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  oagu_nest_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .step  (accept),
    .x_len (x_len),
    .y_len (y_len),
    .p_len (p_len),
    .last  (last)
  );

  // NOTE: the datapath registers are reset too, because a reset must leave
  // the write port reading all zeros rather than a stale address or value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      x_len     <= '0;
      y_len     <= '0;
      p_len     <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_write) begin
            addr  <= addr_start_d;
            x_len <= out_x_length;
            y_len <= out_y_length;
            p_len <= out_piece;
            if (out_x_length == 8'd0 || out_y_length == 8'd0 || out_piece == 8'd0)
              state <= ST_DONE;
            else
              state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The walk is linear in x, then y, then p, so the address is a plain increment.
          if (accept) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= addr;
            o_wr_data <= wr_value(i_res_data);
            addr      <= addr + 1'b1;
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/oagu_writeback.md
OAGU_WRITEBACK -- requirements
Module: oagu_writeback

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the result/write data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 13, giving the IO buffer address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_write, input, 1 bit: one-cycle pulse from the scheduler that starts a layer write-back.
REQ-006 The block SHALL have port addr_start_d, input, ADDR_W bits: output base address in the IO buffer.
REQ-007 The block SHALL have ports out_x_length, out_y_length and out_piece, each input, 8 bits: output width, height and piece count.
REQ-008 The block SHALL have port i_res_valid, input, 1 bit: an NPE result beat is present.
REQ-009 The block SHALL have port i_res_data, input, DATA_W bits: the NPE result value.
REQ-010 The block SHALL have port o_res_ready, output, 1 bit: the block accepts a result beat this cycle.
REQ-011 The block SHALL have ports o_wr_addr (output, ADDR_W bits), o_wr_data (output, DATA_W bits) and o_wr_en (output, 1 bit): the IO buffer write port.
REQ-012 The block SHALL have port o_busy, output, 1 bit, high in every state except IDLE.
REQ-013 The block SHALL have port o_write_end, output, 1 bit: one-cycle pulse when the layer is complete.

Function
REQ-014 The state machine SHALL have three states, IDLE, WRITE and DONE.
- REQ-015 IDLE->WRITE SHALL occur on start_write when all three lengths are nonzero.
- REQ-016 IDLE->DONE SHALL occur on start_write when any length is zero; no write is issued.
- REQ-017 WRITE->DONE SHALL occur on acceptance of the last beat.
- REQ-018 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-019 On start_write in IDLE, the block SHALL register addr_start_d and all lengths. Later input changes SHALL be ignored until the next start.
REQ-020 start_write SHALL be ignored outside IDLE.
REQ-021 o_res_ready SHALL equal (state==WRITE). A beat is accepted when i_res_valid && o_res_ready.
REQ-022 Counters x, y and p SHALL start at 0. Iteration order SHALL be x fastest, then y, then p; each counter wraps to 0 at length-1 and carries into the next.
REQ-023 The address of an accepted beat SHALL be base + p*out_x_length*out_y_length + y*out_x_length + x, truncated modulo 2^ADDR_W.
REQ-024 The address SHALL be kept as an incrementing register; no multiplier SHALL be used.
REQ-025 The last beat SHALL be x==out_x_length-1, y==out_y_length-1 and p==out_piece-1.
REQ-026 Latency SHALL be 1 cycle: a beat accepted in cycle N drives o_wr_en=1 with its address and data in cycle N+1. o_wr_en SHALL be 0 in every other cycle.
REQ-027 o_write_end SHALL pulse in the DONE cycle, which is the same cycle as the last o_wr_en.
REQ-028 For a zero-length start, o_write_end SHALL pulse in the cycle after start_write.
REQ-029 The block SHALL apply no backpressure from the IO buffer; it accepts one write every cycle.
REQ-030 i_res_valid in IDLE or DONE SHALL be dropped with no write issued.

Reset
REQ-031 While rst is low, the block SHALL force state=IDLE, all counters and registers to 0, and o_res_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_write_end=0.
REQ-032 Reset asserted mid-layer SHALL abandon the layer. No o_write_end SHALL be issued, and the next start SHALL begin fresh.

Configuration
REQ-033 With OAGU_RELU_EN defined, o_wr_data SHALL be 0 when the signed i_res_data is negative, and i_res_data otherwise.
REQ-034 With OAGU_RELU_EN undefined, o_wr_data SHALL equal i_res_data unchanged; all timing SHALL be identical in both builds.

Structure
REQ-035 Shared package npu_pkg SHALL hold the ADDR_W default of 13, the mode constants (CONV=1, FC=2, ADD=3, POOL=4, ACC=5, DEPTHCONV=6) and the state enum.
REQ-036 The design SHALL contain one sub-module, oagu_nest_cnt, implementing the x/y/p nested counter with a last flag.

Verification
REQ-037 Basic layer: base=0x100, x=2, y=2, p=2, valid held high -> 8 writes at addresses 0x100..0x107 on consecutive cycles, then o_write_end with the 8th write.
REQ-038 Wrap-around: base=0x1FFE, x=4, y=1, p=1 -> writes at 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-039 Gapped valid: x=3, y=1, p=1, valid=1,0,1,0,1 -> 3 writes, each 1 cycle after its accepted beat, at base+0, base+1, base+2.
REQ-040 Zero length: out_y_length=0 -> no o_wr_en, o_write_end 1 cycle after start, o_busy high for exactly 1 cycle.
REQ-041 Reset mid-layer: rst low after 3 of 8 beats -> all outputs 0 and no o_write_end; a new start at base 0x000 writes from 0x000.
REQ-042 ReLU: with OAGU_RELU_EN defined, data 0xFFF0 is written as 0x0000 and 0x0010 is written as 0x0010; with it undefined, 0xFFF0 is written unchanged.
